// File: rtl/mux_decoded_pipe_if.sv
// Request/response bundle for mux_decoded_pipe: one-hot way select in,
// pipelined selected way plus status out, valid/ready on both sides.
interface mux_decoded_pipe_if #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 32,
  parameter int NUMBER_WAY               = 8,
  parameter int ERR_CNT_WIDTH            = 16
) ();
  localparam int IDX_W = $clog2(NUMBER_WAY);

  logic                                           request_valid_in;
  logic                                           request_ready_out;
  logic [SINGLE_WAY_WIDTH_IN_BITS*NUMBER_WAY-1:0] way_flatted_in;
  logic [NUMBER_WAY-1:0]                          sel_in;
  logic                                           err_clear_in;
  logic                                           valid_out;
  logic                                           ready_in;
  logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]            way_flatted_out;
  logic [IDX_W-1:0]                               way_index_out;
  logic                                           hit_out;
  logic                                           multi_hot_out;
  logic [ERR_CNT_WIDTH-1:0]                       multi_hot_count_out;

  modport slave (
    input  request_valid_in, way_flatted_in, sel_in, err_clear_in, ready_in,
    output request_ready_out, valid_out, way_flatted_out, way_index_out,
           hit_out, multi_hot_out, multi_hot_count_out
  );

  modport master (
    output request_valid_in, way_flatted_in, sel_in, err_clear_in, ready_in,
    input  request_ready_out, valid_out, way_flatted_out, way_index_out,
           hit_out, multi_hot_out, multi_hot_count_out
  );
endinterface

// File: rtl/mux_decoded_pipe.sv
// One-hot way mux with priority resolution for multi-hot selects, carried
// through NUM_STAGES elastic valid/ready stages, plus a saturating multi-hot counter.
module mux_decoded_pipe #(
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 32,
  parameter int NUMBER_WAY               = 8,
  parameter int NUM_STAGES               = 2,
  parameter int PRIORITY_HIGH            = 0,
  parameter int ERR_CNT_WIDTH            = 16
) (
  input logic             clk_in,
  input logic             reset_n_in,
  mux_decoded_pipe_if.slave bus
);
  localparam int W     = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int IDX_W = $clog2(NUMBER_WAY);
  localparam int LAST  = NUM_STAGES - 1;

  logic [W-1:0]     sel_data;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_hit;
  logic             sel_mh;
  logic             in_xfer;

  // Later loop iterations overwrite earlier ones, so the scan direction picks the winner.
  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    if (PRIORITY_HIGH != 0) begin
      for (int k = 0; k < NUMBER_WAY; k++) begin
        if (bus.sel_in[k]) begin
          sel_idx  = IDX_W'(k);
          sel_data = bus.way_flatted_in[k*W +: W];
        end
      end
    end else begin
      for (int k = NUMBER_WAY - 1; k >= 0; k--) begin
        if (bus.sel_in[k]) begin
          sel_idx  = IDX_W'(k);
          sel_data = bus.way_flatted_in[k*W +: W];
        end
      end
    end
  end

  assign sel_hit = |bus.sel_in;
  assign sel_mh  = |(bus.sel_in & (bus.sel_in - NUMBER_WAY'(1)));

  logic [NUM_STAGES-1:0] vld_q;
  logic [NUM_STAGES-1:0] vld_d;
  logic [NUM_STAGES-1:0] stage_rdy;
  logic [W-1:0]          data_q [NUM_STAGES];
  logic [W-1:0]          data_d [NUM_STAGES];
  logic [IDX_W-1:0]      idx_q  [NUM_STAGES];
  logic [IDX_W-1:0]      idx_d  [NUM_STAGES];
  logic [NUM_STAGES-1:0] hit_q;
  logic [NUM_STAGES-1:0] hit_d;
  logic [NUM_STAGES-1:0] mh_q;
  logic [NUM_STAGES-1:0] mh_d;

  // Stage i may load if any stage from i to the end holds a bubble or the
  // consumer is taking the output; expanded so no signal feeds itself.
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_rdy[i] = bus.ready_in;
      for (int j = i; j < NUM_STAGES; j++) begin
        if (!vld_q[j]) stage_rdy[i] = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d[0]  = bus.request_valid_in;
    data_d[0] = sel_data;
    idx_d[0]  = sel_idx;
    hit_d[0]  = sel_hit;
    mh_d[0]   = sel_mh;
    for (int i = 1; i < NUM_STAGES; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
      idx_d[i]  = idx_q[i-1];
      hit_d[i]  = hit_q[i-1];
      mh_d[i]   = mh_q[i-1];
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      vld_q <= '0;
      hit_q <= '0;
      mh_q  <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (stage_rdy[i]) begin
          vld_q[i] <= vld_d[i];
          if (vld_d[i]) begin
            data_q[i] <= data_d[i];
            idx_q[i]  <= idx_d[i];
            hit_q[i]  <= hit_d[i];
            mh_q[i]   <= mh_d[i];
          end
        end
      end
    end
  end

  logic [ERR_CNT_WIDTH-1:0] cnt_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_d;

  assign in_xfer = bus.request_valid_in && stage_rdy[0];

  // Clear wins over a same-cycle increment.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.err_clear_in) begin
      cnt_d = '0;
    end else if (in_xfer && sel_mh && !(&cnt_q)) begin
      cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end

  assign bus.request_ready_out   = stage_rdy[0];
  assign bus.valid_out           = vld_q[LAST];
  assign bus.way_flatted_out     = data_q[LAST];
  assign bus.way_index_out       = idx_q[LAST];
  assign bus.hit_out             = hit_q[LAST];
  assign bus.multi_hot_out       = mh_q[LAST];
  assign bus.multi_hot_count_out = cnt_q;
endmodule

// File: tb/tb_mux_decoded_pipe.sv
// Bench for mux_decoded_pipe: two instances (low and high priority, 16- and
// 2-bit counters) share stimulus; a scoreboard queue feeds an output monitor.
module tb_mux_decoded_pipe;
  localparam int NS = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         clr;
  logic         rdy;
  logic [7:0]   sel;
  logic [255:0] ways;

  int n_cmp    = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int accepted = 0;
  bit lat_on   = 1'b0;

  typedef struct {
    logic [31:0] dlo;
    logic [31:0] dhi;
    logic [2:0]  ilo;
    logic [2:0]  ihi;
    logic        hit;
    logic        mh;
    int          stamp;
    bit          lat;
  } exp_t;

  exp_t sb[$];

  // Hand-computed expectations, way k = A000_0000 + k.
  logic [7:0]  v_sel [8] = '{8'h01, 8'h08, 8'h80, 8'h14, 8'h00, 8'hFF, 8'h81, 8'h10};
  logic [31:0] v_dlo [8] = '{32'hA000_0000, 32'hA000_0003, 32'hA000_0007, 32'hA000_0002,
                             32'h0000_0000, 32'hA000_0000, 32'hA000_0000, 32'hA000_0004};
  logic [2:0]  v_ilo [8] = '{3'd0, 3'd3, 3'd7, 3'd2, 3'd0, 3'd0, 3'd0, 3'd4};
  logic [31:0] v_dhi [8] = '{32'hA000_0000, 32'hA000_0003, 32'hA000_0007, 32'hA000_0004,
                             32'h0000_0000, 32'hA000_0007, 32'hA000_0007, 32'hA000_0004};
  logic [2:0]  v_ihi [8] = '{3'd0, 3'd3, 3'd7, 3'd4, 3'd0, 3'd7, 3'd7, 3'd4};
  logic        v_hit [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic        v_mh  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  mux_decoded_pipe_if #(.SINGLE_WAY_WIDTH_IN_BITS(32), .NUMBER_WAY(8), .ERR_CNT_WIDTH(16)) if_a ();
  mux_decoded_pipe_if #(.SINGLE_WAY_WIDTH_IN_BITS(32), .NUMBER_WAY(8), .ERR_CNT_WIDTH(2))  if_b ();

  assign if_a.request_valid_in = req_valid;
  assign if_a.way_flatted_in   = ways;
  assign if_a.sel_in           = sel;
  assign if_a.err_clear_in     = clr;
  assign if_a.ready_in         = rdy;
  assign if_b.request_valid_in = req_valid;
  assign if_b.way_flatted_in   = ways;
  assign if_b.sel_in           = sel;
  assign if_b.err_clear_in     = clr;
  assign if_b.ready_in         = rdy;

  mux_decoded_pipe #(
    .SINGLE_WAY_WIDTH_IN_BITS(32), .NUMBER_WAY(8), .NUM_STAGES(NS),
    .PRIORITY_HIGH(0), .ERR_CNT_WIDTH(16)
  ) u_dut_lo (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .bus        (if_a)
  );

  mux_decoded_pipe #(
    .SINGLE_WAY_WIDTH_IN_BITS(32), .NUMBER_WAY(8), .NUM_STAGES(NS),
    .PRIORITY_HIGH(1), .ERR_CNT_WIDTH(2)
  ) u_dut_hi (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .bus        (if_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int v, input bit c);
    exp_t e;
    bit   done;
    done      = 1'b0;
    req_valid = 1'b1;
    sel       = v_sel[v];
    clr       = c;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (if_a.request_ready_out) begin
        e.dlo   = v_dlo[v];
        e.dhi   = v_dhi[v];
        e.ilo   = v_ilo[v];
        e.ihi   = v_ihi[v];
        e.hit   = v_hit[v];
        e.mh    = v_mh[v];
        e.stamp = cyc;
        e.lat   = lat_on;
        sb.push_back(e);
        accepted++;
        done = 1'b1;
      end
    end
    chk("send_accepted", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic chk_counts(input string tag, input int ea, input int eb);
    chk({tag, "_cnt_lo"}, if_a.multi_hot_count_out, ea);
    chk({tag, "_cnt_hi"}, if_b.multi_hot_count_out, eb);
  endtask

  // Output monitor: pops on each handshake and checks hold-stability under stall.
  bit          stall = 1'b0;
  logic [31:0] held_data;
  logic [2:0]  held_idx;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", if_a.valid_out, 1);
        chk("hold_data", if_a.way_flatted_out, held_data);
        chk("hold_index", if_a.way_index_out, held_idx);
      end
      if (if_a.valid_out) begin
        chk("valid_hi_inst", if_b.valid_out, 1);
        if (rdy) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: got data %0h with empty scoreboard, required no beat",
                     if_a.way_flatted_out);
          end else begin
            e = sb.pop_front();
            chk("data_lo", if_a.way_flatted_out, e.dlo);
            chk("index_lo", if_a.way_index_out, e.ilo);
            chk("hit_lo", if_a.hit_out, e.hit);
            chk("multi_hot_lo", if_a.multi_hot_out, e.mh);
            chk("data_hi", if_b.way_flatted_out, e.dhi);
            chk("index_hi", if_b.way_index_out, e.ihi);
            chk("hit_hi", if_b.hit_out, e.hit);
            chk("multi_hot_hi", if_b.multi_hot_out, e.mh);
            if (e.lat) chk("latency", cyc - e.stamp, NS);
          end
        end
      end
      stall     = if_a.valid_out && !rdy;
      held_data = if_a.way_flatted_out;
      held_idx  = if_a.way_index_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    clr       = 1'b0;
    rdy       = 1'b1;
    sel       = '0;
    for (int k = 0; k < 8; k++) ways[k*32 +: 32] = 32'hA000_0000 + k;

    #3;
    chk("reset_valid", if_a.valid_out, 0);
    chk_counts("reset", 0, 0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_ready_lo", if_a.request_ready_out, 1);
    chk("reset_ready_hi", if_b.request_ready_out, 1);

    // Streaming, back-to-back, latency checked
    lat_on = 1'b1;
    send(0, 0);
    send(1, 0);
    send(2, 0);
    idle();
    lat_on = 1'b0;
    drain();

    // Multi-hot priority, then zero-hot
    send(3, 0);
    idle();
    chk_counts("mh_first", 1, 1);
    send(4, 0);
    idle();
    chk_counts("zero_hot", 1, 1);
    drain();

    // Backpressure: two beats fill the pipe, the rest wait
    rdy  = 1'b0;
    acc0 = accepted;
    fork
      begin
        send(7, 0);
        send(0, 0);
        send(1, 0);
        send(2, 0);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_ready_low", if_a.request_ready_out, 0);
        chk("bp_accepts", accepted - acc0, 2);
        @(posedge clk);
        #1;
        rdy = 1'b1;
      end
    join
    drain();

    // Counter clear, saturation, and clear beating a same-cycle increment
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk_counts("clear", 0, 0);
    send(3, 0);
    send(5, 0);
    send(6, 0);
    send(3, 0);
    send(5, 0);
    idle();
    chk_counts("saturate", 5, 3);
    send(6, 1);
    idle();
    chk_counts("clear_prio", 0, 0);
    drain();

    // Async reset with two beats in flight
    send(3, 0);
    send(5, 0);
    idle();
    chk_counts("pre_reset", 2, 2);
    chk("pre_reset_valid", if_a.valid_out, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid_lo", if_a.valid_out, 0);
    chk("async_valid_hi", if_b.valid_out, 0);
    chk("async_data", if_a.way_flatted_out, 0);
    chk_counts("async", 0, 0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready_lo", if_a.request_ready_out, 1);
    chk("post_reset_ready_hi", if_b.request_ready_out, 1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    send(7, 0);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_decoded_pipe.md
Name: mux_decoded_pipe

Overview:
- Pipelined, flow-controlled successor to the combinational one-hot way mux.
- Selects one SINGLE_WAY_WIDTH_IN_BITS slice from NUMBER_WAY flattened ways using a decoded (one-hot) select vector.
- Carries the result through NUM_STAGES elastic register stages with valid/ready handshake.
- Also reports the selected index, hit/no-hit, multi-hot select errors and a saturating error counter. Sits between tag-compare and the data-return path in the cache read pipeline.

Parameters:
- SINGLE_WAY_WIDTH_IN_BITS, 32, width of one way slice.
- NUMBER_WAY, 8, number of ways (>=2).
- NUM_STAGES, 2, register stages from input to output (1..4).
- PRIORITY_HIGH, 0, 0 = lowest set select bit wins, 1 = highest set select bit wins.
- ERR_CNT_WIDTH, 16, width of multi-hot error counter.

Ports:
- clk_in  input  1  clock, all state on rising edge.
- reset_n_in  input  1  reset, asynchronous, active-low.
- request_valid_in  input  1  input beat valid.
- request_ready_out  output  1  block can accept input beat.
- way_flatted_in  input  SINGLE_WAY_WIDTH_IN_BITS*NUMBER_WAY  way data; way k at bits [k*W +: W].
- sel_in  input  NUMBER_WAY  decoded select.
- err_clear_in  input  1  synchronous clear of error counter.
- valid_out  output  1  output beat valid.
- ready_in  input  1  consumer accepts output beat.
- way_flatted_out  output  SINGLE_WAY_WIDTH_IN_BITS  selected way.
- way_index_out  output  $clog2(NUMBER_WAY)  index of selected way.
- hit_out  output  1  at least one select bit was set.
- multi_hot_out  output  1  more than one select bit was set.
- multi_hot_count_out  output  ERR_CNT_WIDTH  saturating count of accepted multi-hot beats.

Behaviour:
- Reset (reset_n_in low, asynchronous):
  - All stage valid bits clear, so valid_out = 0.
  - Data, index, hit and multi-hot registers clear to 0.
  - multi_hot_count_out = 0.
  - request_ready_out = 1 as soon as reset releases.
  - Reset mid-operation discards all in-flight beats; no partial output.
- Select resolution (combinational at input, before stage 0):
  - PRIORITY_HIGH=0: index of lowest set bit. PRIORITY_HIGH=1: index of highest set bit.
  - hit = |sel_in. multi_hot = hit and popcount(sel_in) > 1.
  - sel_in all zero: index 0, data all zeros (not way 0 data), hit = 0, multi_hot = 0.
- Pipeline (stages 0..NUM_STAGES-1; last stage drives the outputs):
  - Each stage holds valid, data, index, hit, multi_hot.
  - Stage i can accept when it is empty or stage i+1 accepts in the same cycle. The last stage can accept when valid_out = 0 or ready_in = 1.
  - request_ready_out = stage 0 can accept. This is combinational from ready_in through the chain; no skid buffer.
  - A transfer occurs when request_valid_in and request_ready_out are both high at a clock edge.
  - Latency with no backpressure: exactly NUM_STAGES cycles from accept to valid_out.
  - Throughput: 1 beat per cycle.
  - Under backpressure (ready_in low), valid_out and all output fields hold stable until accepted. Bubbles collapse: empty stages fill while later stages stall.
  - Order is preserved; no beat is dropped or duplicated.
- Error counter:
  - Increments by 1 on each accepted input beat with multi_hot = 1.
  - Saturates at all-ones; never wraps.
  - err_clear_in has priority over increment in the same cycle: counter goes to 0 and that beat is not counted.
- Width rules:
  - way_index_out is $clog2(NUMBER_WAY) bits.
  - For non-power-of-2 NUMBER_WAY, the index never exceeds NUMBER_WAY-1.
- Output legality: when valid_out = 0, output data is don't-care. The bench checks fields only when valid_out = 1.

Test Plan:
- Streaming select: NUMBER_WAY=8, W=32, NUM_STAGES=2, way k = 32'hA000_0000+k. Send sel 8'h01, 8'h08, 8'h80 back-to-back with ready_in=1 -> outputs A000_0000/0, A000_0003/3, A000_0007/7 on cycles 2, 3, 4 after first accept; hit=1, multi_hot=0.
- Multi-hot priority: sel=8'h14 with PRIORITY_HIGH=0 -> index 2, multi_hot=1, counter 0->1. Same stimulus with PRIORITY_HIGH=1 -> index 4.
- Zero-hot: sel=8'h00 -> valid_out after 2 cycles, data 0, index 0, hit=0, counter unchanged.
- Backpressure: hold ready_in=0 and stream 4 beats -> request_ready_out drops after 2 accepts; valid_out data stays stable. Release ready_in -> remaining beats emerge in order, none lost.
- Counter saturation/clear: ERR_CNT_WIDTH=2, send 5 multi-hot beats -> count 3. Assert err_clear_in in the same cycle as a 6th multi-hot accept -> count 0.
- Async reset mid-flight: assert reset_n_in low between clock edges with 2 beats in flight -> valid_out=0 immediately and counter=0. After release, request_ready_out=1 and no stale beat appears.
